surf_cout_align_ctrl: RTL and testbench



---
 rtl/surf_align_pkg.sv | 55 +++++
 rtl/surf_cout_align_ctrl_eye.sv | 50 +++++
 rtl/surf_cout_align_ctrl.sv | 279 +++++++++++++++++++++++++++
 tb/tb_surf_cout_align_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/surf_align_pkg.sv
// Shared types for the SURF COUT/DOUT receive alignment controller.
// Holds the FSM state, lane select, tap type and pattern helpers.
package surf_align_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_SCAN,
      ST_EVAL,
      ST_CENTER,
      ST_CSETTLE,
      ST_SLIP_CHECK,
      ST_SLIP_WAIT,
      ST_NEXT_LANE,
      ST_DONE,
      ST_FAIL
   } state_t;

   typedef enum logic {
      LANE_COUT = 1'b0,
      LANE_DOUT = 1'b1
   } lane_t;

   typedef logic [4:0] tap_t;

   localparam tap_t LAST_TAP = 5'd31;

   function automatic logic is_rot4(
      input logic [3:0] w,
      input logic [3:0] p
   );
      logic [7:0] pp;
      logic       hit;
      pp  = {p, p};
      hit = 1'b0;
      for (int i = 0; i < 4; i++)
         if (pp[i +: 4] == w) hit = 1'b1;
      return hit;
   endfunction

   function automatic logic is_rot8(
      input logic [7:0] w,
      input logic [7:0] p
   );
      logic [15:0] pp;
      logic        hit;
      pp  = {p, p};
      hit = 1'b0;
      for (int i = 0; i < 8; i++)
         if (pp[i +: 8] == w) hit = 1'b1;
      return hit;
   endfunction

endpackage

// File: rtl/surf_cout_align_ctrl_eye.sv
// Longest-run tracker over a monotonic tap sweep.
// The first run found wins ties; centre is floored.
module surf_eye_tracker
   import surf_align_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       step,
   input  logic       good,
   input  tap_t       tap,
   output tap_t       best_start,
   output logic [5:0] best_len,
   output tap_t       centre
);

   tap_t       cur_start;
   logic [5:0] cur_len;
   tap_t       run_start;
   logic [5:0] run_len;

   always_comb begin
      run_start = (cur_len == 6'd0) ? tap : cur_start;
      run_len   = cur_len + 6'd1;
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cur_start  <= '0;
         cur_len    <= '0;
         best_start <= '0;
         best_len   <= '0;
      end else if (step) begin
         if (good) begin
            cur_start <= run_start;
            cur_len   <= run_len;
            if (run_len > best_len) begin
               best_start <= run_start;
               best_len   <= run_len;
            end
         end else begin
            cur_len <= '0;
         end
      end
   end

   // start + len/2 never exceeds 31 since the run ends by tap 31
   assign centre = best_start + best_len[5:1];

endmodule

// File: rtl/surf_cout_align_ctrl.sv
// COUT/DOUT receive training: IDELAY eye sweep, centre load,
// then bitslip until the deserialized word equals the pattern.
module surf_cout_align_ctrl
   import surf_align_pkg::*;
#(
   parameter logic [3:0]  COUT_PATTERN  = 4'b1000,
   parameter logic [7:0]  DOUT_PATTERN  = 8'hB8,
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter int unsigned WINDOW        = 256,
   parameter int unsigned SLIP_WAIT     = 4,
   parameter int unsigned MIN_EYE       = 4
)(
   input  logic       sysclk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [3:0] cout_i,
   input  logic [7:0] dout_i,
   output logic [4:0] idelay_value_o,
   output logic       idelay_cout_load_o,
   output logic       idelay_dout_load_o,
   output logic       iserdes_cout_bitslip_o,
   output logic       iserdes_dout_bitslip_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       fail_o,
   output logic       fail_lane_o,
   output logic [4:0] cout_tap_o,
   output logic [4:0] dout_tap_o
);

   localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [15:0] WIN_LAST    = 16'(WINDOW - 1);
   localparam logic [7:0]  SWAIT_LAST  = 8'(SLIP_WAIT - 1);
   localparam logic [5:0]  MIN_LEN     = 6'(MIN_EYE);

   state_t      state_q, state_d;
   lane_t       lane_q, lane_d;
   tap_t        tap_q, tap_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] win_q, win_d;
   logic [3:0]  slips_q, slips_d;
   logic [7:0]  prev_q, prev_d;
   logic        stable_q, stable_d;
   logic        good_q, good_d;

   tap_t        idly_q, idly_d;
   tap_t        ctap_q, ctap_d;
   tap_t        dtap_q, dtap_d;
   logic        done_q, done_d;
   logic        fail_q, fail_d;
   logic        flane_q, flane_d;
   logic        busy_d;
   logic        cload_q, dload_q;
   logic        cslip_q, dslip_q;
   logic        load_d, slip_d;

   logic        trk_clear, trk_step;
   tap_t        unused_best_start;
   logic [5:0]  eye_len;
   tap_t        eye_centre;

   logic [7:0]  word;
   logic        word_rot;
   logic        word_match;
   logic [3:0]  lane_w;

   surf_eye_tracker u_eye (
      .clk        (sysclk_i),
      .rst        (rst_i),
      .clear      (trk_clear),
      .step       (trk_step),
      .good       (good_q),
      .tap        (tap_q),
      .best_start (unused_best_start),
      .best_len   (eye_len),
      .centre     (eye_centre)
   );

   always_comb begin
      if (lane_q == LANE_COUT) begin
         word       = {4'b0000, cout_i};
         word_rot   = is_rot4(cout_i, COUT_PATTERN);
         word_match = (cout_i == COUT_PATTERN);
         lane_w     = 4'd4;
      end else begin
         word       = dout_i;
         word_rot   = is_rot8(dout_i, DOUT_PATTERN);
         word_match = (dout_i == DOUT_PATTERN);
         lane_w     = 4'd8;
      end
   end

   always_comb begin
      state_d   = state_q;
      lane_d    = lane_q;
      tap_d     = tap_q;
      cnt_d     = cnt_q;
      win_d     = win_q;
      slips_d   = slips_q;
      prev_d    = prev_q;
      stable_d  = stable_q;
      good_d    = good_q;
      idly_d    = idly_q;
      ctap_d    = ctap_q;
      dtap_d    = dtap_q;
      done_d    = done_q;
      fail_d    = fail_q;
      flane_d   = flane_q;
      load_d    = 1'b0;
      slip_d    = 1'b0;
      trk_clear = 1'b0;
      trk_step  = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE, ST_FAIL: begin
            if (start_i) begin
               state_d   = ST_LOAD;
               lane_d    = LANE_COUT;
               tap_d     = '0;
               trk_clear = 1'b1;
               done_d    = 1'b0;
               fail_d    = 1'b0;
               flane_d   = 1'b0;
               ctap_d    = '0;
               dtap_d    = '0;
            end
         end
         ST_LOAD: begin
            cnt_d   = '0;
            state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == SETTLE_LAST) begin
               win_d   = '0;
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            win_d  = win_q + 16'd1;
            prev_d = word;
            if (win_q == 16'd0)
               stable_d = 1'b1;
            else if (word != prev_q)
               stable_d = 1'b0;
            if (win_q == WIN_LAST) begin
               good_d  = stable_d && word_rot;
               state_d = ST_EVAL;
            end
         end
         ST_EVAL: begin
            trk_step = 1'b1;
            if (tap_q == LAST_TAP) begin
               state_d = ST_CENTER;
            end else begin
               tap_d   = tap_q + 5'd1;
               state_d = ST_LOAD;
            end
         end
         ST_CENTER: begin
            if (eye_len < MIN_LEN) begin
               state_d = ST_FAIL;
               fail_d  = 1'b1;
               flane_d = lane_q;
            end else begin
               tap_d   = eye_centre;
               idly_d  = eye_centre;
               load_d  = 1'b1;
               slips_d = '0;
               cnt_d   = '0;
               state_d = ST_CSETTLE;
            end
         end
         ST_CSETTLE: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == SETTLE_LAST)
               state_d = ST_SLIP_CHECK;
         end
         ST_SLIP_CHECK: begin
            if (word_match) begin
               if (lane_q == LANE_COUT)
                  ctap_d = tap_q;
               else
                  dtap_d = tap_q;
               state_d = ST_NEXT_LANE;
            end else if (slips_q == lane_w) begin
               state_d = ST_FAIL;
               fail_d  = 1'b1;
               flane_d = lane_q;
            end else begin
               slip_d  = 1'b1;
               slips_d = slips_q + 4'd1;
               cnt_d   = '0;
               state_d = ST_SLIP_WAIT;
            end
         end
         ST_SLIP_WAIT: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == SWAIT_LAST)
               state_d = ST_SLIP_CHECK;
         end
         ST_NEXT_LANE: begin
            if (lane_q == LANE_COUT) begin
               lane_d    = LANE_DOUT;
               tap_d     = '0;
               trk_clear = 1'b1;
               state_d   = ST_LOAD;
            end else begin
               done_d  = 1'b1;
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // every sweep step enters LOAD with the tap to present
      if (state_d == ST_LOAD) begin
         load_d = 1'b1;
         idly_d = tap_d;
      end
      busy_d = !(state_d inside {ST_IDLE, ST_DONE, ST_FAIL});
   end

   always_ff @(posedge sysclk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         lane_q   <= LANE_COUT;
         tap_q    <= '0;
         cnt_q    <= '0;
         win_q    <= '0;
         slips_q  <= '0;
         prev_q   <= '0;
         stable_q <= 1'b0;
         good_q   <= 1'b0;
         idly_q   <= '0;
         ctap_q   <= '0;
         dtap_q   <= '0;
         done_q   <= 1'b0;
         fail_q   <= 1'b0;
         flane_q  <= 1'b0;
         busy_o   <= 1'b0;
         cload_q  <= 1'b0;
         dload_q  <= 1'b0;
         cslip_q  <= 1'b0;
         dslip_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         lane_q   <= lane_d;
         tap_q    <= tap_d;
         cnt_q    <= cnt_d;
         win_q    <= win_d;
         slips_q  <= slips_d;
         prev_q   <= prev_d;
         stable_q <= stable_d;
         good_q   <= good_d;
         idly_q   <= idly_d;
         ctap_q   <= ctap_d;
         dtap_q   <= dtap_d;
         done_q   <= done_d;
         fail_q   <= fail_d;
         flane_q  <= flane_d;
         busy_o   <= busy_d;
         cload_q  <= load_d && (lane_d == LANE_COUT);
         dload_q  <= load_d && (lane_d == LANE_DOUT);
         cslip_q  <= slip_d && (lane_q == LANE_COUT);
         dslip_q  <= slip_d && (lane_q == LANE_DOUT);
      end
   end

   assign idelay_value_o         = idly_q;
   assign idelay_cout_load_o     = cload_q;
   assign idelay_dout_load_o     = dload_q;
   assign iserdes_cout_bitslip_o = cslip_q;
   assign iserdes_dout_bitslip_o = dslip_q;
   assign done_o                 = done_q;
   assign fail_o                 = fail_q;
   assign fail_lane_o            = flane_q;
   assign cout_tap_o             = ctap_q;
   assign dout_tap_o             = dtap_q;

endmodule

// File: tb/tb_surf_cout_align_ctrl.sv
// Scoreboard bench for surf_cout_align_ctrl with a behavioural PHY
// model whose eye, rotation and bitslip behaviour are scenario driven.
module tb_surf_cout_align_ctrl;

   localparam int SET  = 8;
   localparam int WIN  = 32;
   localparam int SW   = 4;
   localparam int MINE = 4;
   localparam logic [3:0] CPAT = 4'b1000;
   localparam logic [7:0] DPAT = 8'hB8;
   localparam int SPACING = 1 + SET + WIN + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] cout = '0;
   logic [7:0] dout = '0;
   logic [4:0] idly;
   logic       cload, dload, cslip, dslip;
   logic       busy, done, fail, flane;
   logic [4:0] ctap, dtap;

   surf_cout_align_ctrl #(
      .COUT_PATTERN  (CPAT),
      .DOUT_PATTERN  (DPAT),
      .SETTLE_CYCLES (SET),
      .WINDOW        (WIN),
      .SLIP_WAIT     (SW),
      .MIN_EYE       (MINE)
   ) dut (
      .sysclk_i               (clk),
      .rst_i                  (rst),
      .start_i                (start),
      .cout_i                 (cout),
      .dout_i                 (dout),
      .idelay_value_o         (idly),
      .idelay_cout_load_o     (cload),
      .idelay_dout_load_o     (dload),
      .iserdes_cout_bitslip_o (cslip),
      .iserdes_dout_bitslip_o (dslip),
      .busy_o                 (busy),
      .done_o                 (done),
      .fail_o                 (fail),
      .fail_lane_o            (flane),
      .cout_tap_o             (ctap),
      .dout_tap_o             (dtap)
   );

   always #5 clk = ~clk;

   typedef struct {
      int done;
      int fail;
      int flane;
      int ctap;
      int dtap;
      int idly;
      int cslips;
      int dslips;
      int dloads;
   } exp_t;

   exp_t sb[$];
   int n_cmp = 0;
   int n_bad = 0;

   // PHY scenario: good-tap masks, stuck-at-zero masks, start rotations
   logic [31:0] cmask, cstuck, dmask, dstuck;
   int crot, drot;
   bit dslip_dead;
   int ctap_m = 0, dtap_m = 0, cslip_m = 0, dslip_m = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [3:0] rot4(input int r);
      logic [3:0] w;
      int k;
      w = CPAT;
      k = ((r % 4) + 4) % 4;
      for (int i = 0; i < k; i++) w = {w[2:0], w[3]};
      return w;
   endfunction

   function automatic logic [7:0] rot8(input int r);
      logic [7:0] w;
      int k;
      w = DPAT;
      k = ((r % 8) + 8) % 8;
      for (int i = 0; i < k; i++) w = {w[6:0], w[7]};
      return w;
   endfunction

   function automatic logic [31:0] span(input int a, input int b);
      logic [31:0] m;
      m = '0;
      for (int i = a; i <= b; i++) m[i] = 1'b1;
      return m;
   endfunction

   // longest run of good taps, earliest start wins on equal length
   function automatic void eye(input logic [31:0] g,
                               output int s, output int l);
      s = 0;
      l = 0;
      for (int a = 0; a < 32; a++) begin
         int n;
         n = 0;
         while (a + n < 32 && g[a + n]) n++;
         if (n > l) begin
            l = n;
            s = a;
         end
      end
   endfunction

   function automatic exp_t ref_model();
      exp_t e;
      int s, l;
      e = '{default: 0};
      eye(cmask, s, l);
      if (l < MINE) begin
         e.fail = 1;
         e.idly = 31;
         return e;
      end
      e.ctap   = s + l / 2;
      e.cslips = crot;
      e.dloads = 32;
      eye(dmask, s, l);
      if (l < MINE) begin
         e.fail  = 1;
         e.flane = 1;
         e.idly  = 31;
         return e;
      end
      e.dloads = 33;
      e.idly   = s + l / 2;
      if (dslip_dead && drot != 0) begin
         e.fail   = 1;
         e.flane  = 1;
         e.dslips = 8;
         return e;
      end
      e.dslips = drot;
      e.dtap   = e.idly;
      e.done   = 1;
      return e;
   endfunction

   // PHY: taps latch on load, slips rotate the word, bad taps are noisy or stuck
   always @(negedge clk) begin
      if (cload) ctap_m = int'(idly);
      if (dload) dtap_m = int'(idly);
      if (cslip) cslip_m++;
      if (dslip && !dslip_dead) dslip_m++;
      if (cmask[ctap_m]) cout = rot4(crot - cslip_m);
      else if (cstuck[ctap_m]) cout = 4'h0;
      else cout = 4'($urandom);
      if (dmask[dtap_m]) dout = rot8(drot - dslip_m);
      else if (dstuck[dtap_m]) dout = 8'h00;
      else dout = 8'($urandom);
   end

   int cyc = 0;
   logic [3:0] pl_prev = '0;
   bit busy_prev = 0, end_prev = 0, f_seen = 0;
   int r_cs = 0, r_ds = 0, r_dl = 0;
   int f_lane = 0, f_val = 0, l_lane = -1, l_val = 0, l_cyc = 0;

   always @(negedge clk) begin
      logic [3:0] pl;
      exp_t e;
      cyc++;
      pl = {cload, dload, cslip, dslip};
      if (rst) begin
         busy_prev = 0;
         end_prev  = 0;
         pl_prev   = '0;
      end else begin
         if (busy && !busy_prev) begin
            r_cs = 0;
            r_ds = 0;
            r_dl = 0;
            f_seen = 0;
            l_lane = -1;
         end
         if (pl != 4'd0) begin
            check("pulse_onehot", $countones(pl), 1);
            check("pulse_width", int'(|(pl & pl_prev)), 0);
         end
         if (cload || dload) begin
            int ln;
            ln = dload ? 1 : 0;
            if (!f_seen) begin
               f_seen = 1;
               f_lane = ln;
               f_val  = int'(idly);
            end
            if (ln == l_lane && int'(idly) == l_val + 1)
               check("load_spacing", cyc - l_cyc, SPACING);
            l_lane = ln;
            l_val  = int'(idly);
            l_cyc  = cyc;
            if (dload) r_dl++;
         end
         if (cslip) r_cs++;
         if (dslip) r_ds++;
         if ((done || fail) && !end_prev) begin
            if (sb.size() == 0) begin
               check("unexpected_end", 1, 0);
            end else begin
               e = sb.pop_front();
               check("done", int'(done), e.done);
               check("fail", int'(fail), e.fail);
               check("fail_lane", int'(flane), e.flane);
               check("cout_tap", int'(ctap), e.ctap);
               check("dout_tap", int'(dtap), e.dtap);
               check("idelay_value", int'(idly), e.idly);
               check("cout_slips", r_cs, e.cslips);
               check("dout_slips", r_ds, e.dslips);
               check("dout_loads", r_dl, e.dloads);
               check("first_load_lane", f_lane, 0);
               check("first_load_tap", f_val, 0);
            end
         end
         busy_prev = busy;
         end_prev  = done || fail;
         pl_prev   = pl;
      end
   end

   task automatic set_sc(input logic [31:0] cm, input logic [31:0] cs,
                         input int cr, input logic [31:0] dm,
                         input logic [31:0] ds, input int dr,
                         input bit dead);
      cmask = cm;
      cstuck = cs;
      crot = cr;
      dmask = dm;
      dstuck = ds;
      drot = dr;
      dslip_dead = dead;
   endtask

   task automatic start_run(input bit push);
      if (push) sb.push_back(ref_model());
      cslip_m = 0;
      dslip_m = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      check("busy_after_start", int'(busy), 1);
      check("done_cleared", int'(done), 0);
      check("fail_cleared", int'(fail), 0);
      check("fail_lane_cleared", int'(flane), 0);
      check("cout_tap_cleared", int'(ctap), 0);
      check("dout_tap_cleared", int'(dtap), 0);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end();
      int i;
      i = 0;
      while (!(done || fail) && i < 20000) begin
         @(negedge clk);
         i++;
      end
      check("run_finished", int'(done || fail), 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_idly"}, int'(idly), 0);
      check({tag, "_pulses"}, int'({cload, dload, cslip, dslip}), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_fail"}, int'(fail), 0);
      check({tag, "_fail_lane"}, int'(flane), 0);
      check({tag, "_cout_tap"}, int'(ctap), 0);
      check({tag, "_dout_tap"}, int'(dtap), 0);
   endtask

   initial begin
      set_sc('0, '0, 0, '0, '0, 0, 0);
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("idle");

      // narrow COUT eye, one slip needed
      set_sc(span(10, 19), '0, 1, span(4, 27), '0, 3, 0);
      start_run(1);
      wait_end();

      // two equal COUT runs: first wins
      set_sc(span(3, 6) | span(20, 23), 32'h0F0F_0000, 0,
             '1, '0, 5, 0);
      start_run(1);
      wait_end();

      // COUT never usable
      set_sc('0, 32'h00FF_00FF, 2, '1, '0, 0, 0);
      start_run(1);
      wait_end();

      // DOUT bitslip has no effect
      set_sc(span(8, 15), '0, 2, span(0, 9), 32'hFFFF_0000, 4, 1);
      start_run(1);
      wait_end();

      // fully open COUT eye, DOUT picks the longer run
      set_sc('1, '0, 3, span(0, 5) | span(20, 22), '0, 7, 0);
      start_run(1);
      wait_end();

      // abort during a DOUT scan, then a clean rerun
      set_sc(span(10, 19), '0, 1, span(4, 27), '0, 3, 0);
      start_run(0);
      for (int i = 0; i < 5000 && r_dl < 2; i++) @(negedge clk);
      check("reached_dout_sweep", int'(r_dl >= 2), 1);
      repeat (SET + 4) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_all_zero("abort");
      @(negedge clk);
      rst = 1'b0;
      start_run(1);
      wait_end();

      // start pulses while busy are ignored
      set_sc(span(3, 6) | span(20, 23), '0, 2, span(1, 30), '0, 6, 0);
      start_run(1);
      repeat (150) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (1500) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_end();

      for (int t = 0; t < 8; t++) begin
         logic [31:0] cm, dm;
         int a, b;
         a  = $urandom_range(0, 31);
         b  = a + $urandom_range(0, 31);
         cm = span(a, (b > 31) ? 31 : b);
         if ($urandom_range(0, 1) == 1) begin
            a  = $urandom_range(0, 31);
            b  = a + $urandom_range(0, 8);
            cm = cm | span(a, (b > 31) ? 31 : b);
         end
         a  = $urandom_range(0, 31);
         b  = a + $urandom_range(0, 31);
         dm = span(a, (b > 31) ? 31 : b);
         set_sc(cm, $urandom, $urandom_range(0, 3), dm, $urandom,
                $urandom_range(0, 7), ($urandom_range(0, 7) == 0));
         start_run(1);
         wait_end();
      end

      check("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
